pulse_receiver: RTL and testbench
=================================

# pulse_receiver

Receiving end of the clocked pulse line produced by the team's pulse generators. Synchronises an asynchronous pulse input into the `clock` domain, detects each high pulse, and measures its width in clock cycles. Reports every accepted pulse through a valid/ready output handshake and keeps a running pulse count. Sits between any pulse source and the logging or checking logic in a `main` testbench.

## Interface

Parameters:
- `WIDTH_BITS`, 8, width of the measured-width counter and the `width` output.
- `COUNT_BITS`, 8, width of the accepted-pulse counter.
- `MIN_WIDTH`, 2, shortest accepted pulse in cycles. Must be ≥ 1.
- `MAX_WIDTH`, 200, longest accepted pulse in cycles. Must satisfy MIN_WIDTH ≤ MAX_WIDTH ≤ 2^WIDTH_BITS − 1.

Ports:
- `clock`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-low; 0 clears all state immediately.
- `signal`  in  1  — asynchronous pulse line.
- `enable`  in  1  — 1 allows new pulses to start a measurement.
- `width`  out  WIDTH_BITS  — width of the last accepted pulse; valid while `valid`=1.
- `valid`  out  1  — an accepted pulse result is pending.
- `ready`  in  1  — consumer accepts the result on an edge where `valid` and `ready` are both 1.
- `count`  out  COUNT_BITS  — accepted pulses since reset; wraps modulo 2^COUNT_BITS.
- `glitch`  out  1  — one-cycle strobe when a pulse shorter than MIN_WIDTH is rejected.
- `overflow`  out  1  — one-cycle strobe when a pulse reaches MAX_WIDTH while still high.
- `dropped`  out  1  — sticky flag; set when a rising edge arrives while a result is pending. Cleared only by reset.

## Operation

- Synchroniser: two flops, `sync1` then `sync2`. `s` = `sync2`; `s_d` is `s` delayed one cycle.
- Rising edge: `s`=1 and `s_d`=0. Falling edge: `s`=0 and `s_d`=1.
- Reset drives `sync1`, `sync2` and `s_d` to 1. A line already high at reset release therefore does not produce an edge; it is measured only after it falls and rises again.
- Reset clears `width`, `valid`, `count`, `glitch`, `overflow` and `dropped` to 0, and sets the state to IDLE.
- FSM states: IDLE, MEASURE, HOLD, STUCK.
  - IDLE: on a rising edge with `enable`=1, load the counter with 1 and go to MEASURE. Edges with `enable`=0 are ignored.
  - MEASURE, `s`=1: increment the counter.
    - If the incremented value would exceed MAX_WIDTH, pulse `overflow`, go to STUCK, and keep the counter at MAX_WIDTH.
  - MEASURE, falling edge with counter < MIN_WIDTH: pulse `glitch`, go to IDLE. `count` is unchanged.
  - MEASURE, falling edge with counter ≥ MIN_WIDTH: copy the counter to `width`, set `valid`, increment `count`, go to HOLD.
  - HOLD: `valid` and `width` are held stable. On `valid`&`ready`, clear `valid` and go to IDLE. A rising edge seen in HOLD sets `dropped`; that pulse is not measured.
  - STUCK: wait for `s`=0, then go to IDLE. No result and no `count` change.
- `enable` falling during MEASURE does not abort the measurement in progress.
- `glitch` and `overflow` are registered and high for exactly one cycle.

## Timing

- Stimulus changes just after a rising edge. `signal` first sampled high at edge k and held high for N samples.
- The FSM sees the rising edge at edge k+2 and the falling edge at edge k+N+2.
- `width`=N, `valid`=1 and the `count` increment all appear after edge k+N+2. Latency is 2 cycles after the line falls.
- With `ready` held at 1, `valid` stays high for exactly one cycle.
- Minimum back-to-back spacing: a new rising edge is measured if it reaches the FSM in IDLE. With `ready`=1, a low gap of 2 cycles is sufficient.
- For a genuinely asynchronous `signal`, the measured width may be ±1 from the true width.

## Test plan

- Assert `reset` low mid-run → all outputs 0 at once, with no clock edge required. Release with `signal`=1 → no `valid` until the line falls and rises again.
- `enable`=1, `ready`=1, 5-cycle pulse → one cycle of `valid` with `width`=5, 7 edges after the first high sample; `count`=1.
- 1-cycle pulse, MIN_WIDTH=2 → `glitch` high for one cycle, `valid` stays 0, `count` unchanged.
- `ready`=0, 3-cycle pulse, then a 4-cycle pulse → `width` holds 3, `dropped`=1, `count`=1. Raise `ready` → `valid` falls on the next edge.
- 250-cycle pulse, MAX_WIDTH=200 → `overflow` strobes once, no `valid`, `count` unchanged. A following 5-cycle pulse is measured as 5.
- 256 accepted 3-cycle pulses, COUNT_BITS=8 → `count` wraps to 0. With `enable`=0, pulses are ignored and `count` is unchanged.

Source files
------------

// File: rtl/pulse_receiver.sv
// Synchronises an async pulse line, measures each high pulse in clock cycles, reports via valid/ready.
// Latency: result appears 2 cycles after the line falls (2-flop synchroniser + edge detect).
// Backpressure: a pending result blocks new measurements; edges arriving meanwhile set sticky dropped.
module pulse_receiver #(
   parameter int WIDTH_BITS = 8,
   parameter int COUNT_BITS = 8,
   parameter int MIN_WIDTH  = 2,
   parameter int MAX_WIDTH  = 200
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  signal,
   input  logic                  enable,
   output logic [WIDTH_BITS-1:0] width,
   output logic                  valid,
   input  logic                  ready,
   output logic [COUNT_BITS-1:0] count,
   output logic                  glitch,
   output logic                  overflow,
   output logic                  dropped
);

   typedef enum logic [1:0] {IDLE, MEASURE, HOLD, STUCK} state_t;

   localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);
   localparam logic [WIDTH_BITS-1:0] MAX_W = WIDTH_BITS'(MAX_WIDTH);

   state_t                state, state_nxt;
   logic                  sync1, sync2, s_d;
   logic                  s, rise, fall;
   logic [WIDTH_BITS-1:0] cnt, cnt_nxt, width_nxt;
   logic [COUNT_BITS-1:0] count_nxt;
   logic                  valid_nxt, glitch_nxt, overflow_nxt, dropped_nxt;

   // Synchroniser idles high so a line already high at reset release gives no edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         s_d   <= 1'b1;
      end else begin
         sync1 <= signal;
         sync2 <= sync1;
         s_d   <= sync2;
      end
   end

   assign s    = sync2;
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      width_nxt    = width;
      valid_nxt    = valid;
      count_nxt    = count;
      glitch_nxt   = 1'b0;
      overflow_nxt = 1'b0;
      dropped_nxt  = dropped;
      case (state)
         IDLE: begin
            if (rise && enable) begin
               cnt_nxt   = WIDTH_BITS'(1);
               state_nxt = MEASURE;
            end
         end
         MEASURE: begin
            if (s) begin
               if (cnt >= MAX_W) begin
                  overflow_nxt = 1'b1;
                  cnt_nxt      = MAX_W;
                  state_nxt    = STUCK;
               end else begin
                  cnt_nxt = cnt + WIDTH_BITS'(1);
               end
            end else if (fall) begin
               if (cnt < MIN_W) begin
                  glitch_nxt = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  width_nxt = cnt;
                  valid_nxt = 1'b1;
                  count_nxt = count + COUNT_BITS'(1);
                  state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (rise) dropped_nxt = 1'b1;
            if (valid && ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         STUCK: begin
            if (!s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         width    <= '0;
         valid    <= 1'b0;
         count    <= '0;
         glitch   <= 1'b0;
         overflow <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         width    <= width_nxt;
         valid    <= valid_nxt;
         count    <= count_nxt;
         glitch   <= glitch_nxt;
         overflow <= overflow_nxt;
         dropped  <= dropped_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_receiver.sv
// Bench for pulse_receiver: directed table, hand-written corner sequences, randomized pulse trains.
// Expected results come from pulse-width rules (reject short, accept in range, overflow long).
module tb_pulse_receiver;

   localparam int MINW = 2;
   localparam int MAXW = 200;
   localparam int EV_GLITCH = -1;
   localparam int EV_OVER   = -2;
   localparam int EV_NONE   = -3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       signal = 1'b0;
   logic       enable = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] width;
   logic       valid;
   logic [7:0] count;
   logic       glitch, overflow, dropped;

   int vectors = 0;
   int miscompares = 0;
   int got[$];
   int exp_q[$];

   typedef struct {
      int w;
      bit en;
      int ev;
      int cnt;
   } vec_t;
   vec_t tbl[8];

   pulse_receiver #(.WIDTH_BITS(8), .COUNT_BITS(8), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW)) dut (
      .clock(clock), .reset(reset), .signal(signal), .enable(enable),
      .width(width), .valid(valid), .ready(ready), .count(count),
      .glitch(glitch), .overflow(overflow), .dropped(dropped)
   );

   always #5 clock = ~clock;

   // Event log: every handshake, glitch strobe and overflow strobe, sampled mid-cycle.
   always @(negedge clock) begin
      if (reset) begin
         if (valid && ready) got.push_back(int'(width));
         if (glitch) got.push_back(EV_GLITCH);
         if (overflow) got.push_back(EV_OVER);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pulse(input int n);
      signal = 1'b1;
      repeat (n) tick();
      signal = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_width"}, int'(width), 0);
      chk({tag, "_valid"}, int'(valid), 0);
      chk({tag, "_count"}, int'(count), 0);
      chk({tag, "_glitch"}, int'(glitch), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_dropped"}, int'(dropped), 0);
   endtask

   function automatic int ref_outcome(input int w);
      if (w < MINW) return EV_GLITCH;
      if (w > MAXW) return EV_OVER;
      return w;
   endfunction

   initial begin
      int acc;
      int w;
      tbl[0] = '{1,   1'b1, EV_GLITCH, 1};
      tbl[1] = '{2,   1'b1, 2,         2};
      tbl[2] = '{200, 1'b1, 200,       3};
      tbl[3] = '{201, 1'b1, EV_OVER,   3};
      tbl[4] = '{250, 1'b1, EV_OVER,   3};
      tbl[5] = '{5,   1'b1, 5,         4};
      tbl[6] = '{7,   1'b0, EV_NONE,   4};
      tbl[7] = '{3,   1'b1, 3,         5};

      #2;
      chk_outputs_zero("por");
      repeat (3) tick();
      reset = 1'b1;
      repeat (4) tick();

      // 5-cycle pulse: result appears after the 7th edge following the first high sample
      got.delete();
      signal = 1'b1;
      for (int t = 1; t <= 9; t++) begin
         tick();
         if (t == 5) signal = 1'b0;
         if (t == 7) chk("lat_early_valid", int'(valid), 0);
         if (t == 8) begin
            chk("lat_valid", int'(valid), 1);
            chk("lat_width", int'(width), 5);
            chk("lat_count", int'(count), 1);
         end
         if (t == 9) chk("lat_valid_one_cycle", int'(valid), 0);
      end
      repeat (3) tick();
      chk("lat_events", got.size(), 1);

      foreach (tbl[i]) begin
         got.delete();
         enable = tbl[i].en;
         pulse(tbl[i].w);
         repeat (6) tick();
         enable = 1'b1;
         if (tbl[i].ev == EV_NONE) begin
            chk($sformatf("tbl%0d_nevents", i), got.size(), 0);
         end else begin
            chk($sformatf("tbl%0d_nevents", i), got.size(), 1);
            chk($sformatf("tbl%0d_event", i), (got.size() > 0) ? got[0] : -99, tbl[i].ev);
         end
         chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
      end

      // Result held under backpressure; second pulse dropped
      got.delete();
      ready = 1'b0;
      pulse(3);
      repeat (3) tick();
      pulse(4);
      repeat (5) tick();
      chk("hold_valid", int'(valid), 1);
      chk("hold_width", int'(width), 3);
      chk("hold_dropped", int'(dropped), 1);
      chk("hold_count", int'(count), 6);
      ready = 1'b1;
      tick();
      chk("hold_release_valid", int'(valid), 0);
      chk("hold_events", got.size(), 1);

      // Asynchronous reset mid-run with a result pending
      ready = 1'b0;
      pulse(4);
      repeat (4) tick();
      chk("prereset_valid", int'(valid), 1);
      #2 reset = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      tick();
      signal = 1'b1;
      tick();
      reset = 1'b1;
      ready = 1'b1;
      got.delete();
      repeat (8) tick();
      chk("rst_high_valid", int'(valid), 0);
      chk("rst_high_events", got.size(), 0);
      signal = 1'b0;
      repeat (3) tick();
      pulse(4);
      repeat (6) tick();
      chk("rst_repulse_events", got.size(), 1);
      chk("rst_repulse_width", (got.size() > 0) ? got[0] : -99, 4);
      chk("rst_repulse_count", int'(count), 1);

      // Count wraps after 256 accepted pulses
      got.delete();
      for (int i = 0; i < 255; i++) begin
         pulse(3);
         repeat (3) tick();
      end
      repeat (4) tick();
      chk("wrap_events", got.size(), 255);
      chk("wrap_count", int'(count), 0);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pulse(3);
         repeat (3) tick();
      end
      repeat (4) tick();
      chk("disabled_count", int'(count), 0);
      chk("disabled_events", got.size(), 255);
      enable = 1'b1;

      // Randomized pulse train with gaps of at least two cycles
      got.delete();
      exp_q.delete();
      acc = 0;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 9) == 0) w = $urandom_range(190, 215);
         else w = $urandom_range(1, 12);
         exp_q.push_back(ref_outcome(w));
         if (ref_outcome(w) > 0) acc = (acc + 1) % 256;
         pulse(w);
         repeat ($urandom_range(2, 6)) tick();
      end
      repeat (6) tick();
      chk("rnd_nevents", got.size(), exp_q.size());
      foreach (exp_q[i])
         chk($sformatf("rnd_event%0d", i), (i < got.size()) ? got[i] : -99, exp_q[i]);
      chk("rnd_count", int'(count), acc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
